instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/instr_fields_enc.sv | 45 ++++
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: mnemonic codes, opcodes and R-type funct values.
// Used by the instruction encoder and the decode-side control unit.
package mips_pkg;

  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,
    MN_SUB  = 5'd1,
    MN_AND  = 5'd2,
    MN_OR   = 5'd3,
    MN_XOR  = 5'd4,
    MN_SLL  = 5'd5,
    MN_SRL  = 5'd6,
    MN_SRA  = 5'd7,
    MN_JR   = 5'd8,
    MN_ADDI = 5'd9,
    MN_ANDI = 5'd10,
    MN_ORI  = 5'd11,
    MN_XORI = 5'd12,
    MN_LW   = 5'd13,
    MN_SW   = 5'd14,
    MN_BEQ  = 5'd15,
    MN_BNE  = 5'd16,
    MN_LUI  = 5'd17,
    MN_J    = 5'd18,
    MN_JAL  = 5'd19
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_fields_enc.sv
// Combinational field assembly of one MIPS word from a mnemonic and its operands.
// Unused fields are forced to zero; codes above MN_JAL flag illegal and yield a nop.
module instr_fields_enc
  import mips_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] instr,
  output logic        illegal
);

  always_comb begin
    instr   = INSTR_NOP;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      MN_SUB:  instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      MN_AND:  instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      MN_OR:   instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      MN_XOR:  instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_XOR};
      MN_SLL:  instr = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      MN_SRL:  instr = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      MN_SRA:  instr = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
      MN_JR:   instr = {OP_RTYPE, rs, 15'd0, FN_JR};
      MN_ADDI: instr = {OP_ADDI, rs, rt, imm};
      MN_ANDI: instr = {OP_ANDI, rs, rt, imm};
      MN_ORI:  instr = {OP_ORI, rs, rt, imm};
      MN_XORI: instr = {OP_XORI, rs, rt, imm};
      MN_LW:   instr = {OP_LW, rs, rt, imm};
      MN_SW:   instr = {OP_SW, rs, rt, imm};
      MN_BEQ:  instr = {OP_BEQ, rs, rt, imm};
      MN_BNE:  instr = {OP_BNE, rs, rt, imm};
      MN_LUI:  instr = {OP_LUI, 5'd0, rt, imm};
      MN_J:    instr = {OP_J, target};
      MN_JAL:  instr = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes accepted mnemonics into MIPS words and buffers them in a FIFO with byte addresses.
// INSTR_ENCODER_CHECK_EN: drop illegal mnemonics and raise sticky err; otherwise emit a nop.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] count,
  output logic        err
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   OCC_ONE  = 1;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);

  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic [31:0]   push_word;
  logic          accept, push, pop;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d;

  instr_fields_enc u_fields (
    .mnem    (mnem),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .target  (target),
    .instr   (enc_word),
    .illegal (enc_illegal)
  );

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign out_instr = mem_q[rd_ptr_q];
  assign out_addr  = BASE_ADDR + {14'd0, count_q, 2'b00};
  assign count     = count_q;
  assign err       = err_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

`ifdef INSTR_ENCODER_CHECK_EN
  assign push      = accept & ~enc_illegal;
  assign push_word = enc_word;
  assign err_d     = err_q | (accept & enc_illegal);
`else
  assign push      = accept;
  assign push_word = enc_illegal ? INSTR_NOP : enc_word;
  assign err_d     = 1'b0;
`endif

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Storage is left unreset; its contents are only observed while out_valid is high.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes model words into a queue, monitor pops and compares.
// Honours INSTR_ENCODER_CHECK_EN for the illegal-mnemonic expectations.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mnem, rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr, out_addr;
  logic [15:0] count;
  logic        err;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mnem      (mnem),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .target    (target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          exp_pops = 0;
  bit          exp_err = 1'b0;
  int          rdy_mode = 2;   // 0 stall, 1 random, 2 always ready

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the mnemonic tables, plain arithmetic on fields.
  function automatic logic [31:0] ref_word(input int m, input logic [4:0] f_rs, f_rt, f_rd, f_sh,
                                           input logic [15:0] f_imm, input logic [25:0] f_tgt);
    int funct_tab[9] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h00, 'h02, 'h03, 'h08};
    int op_tab[9]    = '{'h08, 'h0C, 'h0D, 'h0E, 'h23, 'h2B, 'h04, 'h05, 'h0F};
    int s_rs, s_rt, s_rd, s_sh;
    s_rs = int'(f_rs); s_rt = int'(f_rt); s_rd = int'(f_rd); s_sh = int'(f_sh);
    if (m <= 8) begin
      if (m >= 5 && m <= 7) s_rs = 0;
      else s_sh = 0;
      if (m == 8) begin s_rt = 0; s_rd = 0; end
      return 32'((s_rs << 21) | (s_rt << 16) | (s_rd << 11) | (s_sh << 6) | funct_tab[m]);
    end else if (m <= 17) begin
      if (m == 17) s_rs = 0;
      return (32'(op_tab[m-9]) << 26) | (32'(s_rs) << 21) | (32'(s_rt) << 16) | 32'(f_imm);
    end else if (m <= 19) begin
      return (32'(m - 16) << 26) | 32'(f_tgt);
    end
    return 32'h0;
  endfunction

  task automatic step(input bit v, input int m, input logic [4:0] a_rs, a_rt, a_rd, a_sh,
                      input logic [15:0] a_imm, input logic [25:0] a_tgt, output bit acc);
    in_valid = v;
    mnem = 5'(m); rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh; imm = a_imm; target = a_tgt;
    acc = v && in_ready && !Reset;
    if (acc) begin
`ifdef INSTR_ENCODER_CHECK_EN
      if (m < 20) exp_q.push_back(ref_word(m, a_rs, a_rt, a_rd, a_sh, a_imm, a_tgt));
      else exp_err = 1'b1;
`else
      exp_q.push_back(ref_word(m, a_rs, a_rt, a_rd, a_sh, a_imm, a_tgt));
`endif
    end
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) @(negedge Clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: chooses out_ready, compares the presented word, pops on a handshake.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge Clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (!Reset && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_instr, 32'hxxxx_xxxx);
        end else begin
          chk("out_instr", out_instr, exp_q[0]);
          chk("out_addr", out_addr, BASE + 32'(exp_pops) * 32'd4);
          chk("count", {16'd0, count}, 32'(exp_pops) & 32'hFFFF);
          if (out_ready) begin
            void'(exp_q.pop_front());
            exp_pops++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int n_acc;
    Reset = 1'b1; in_valid = 1'b0;
    mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err", {31'd0, err}, 32'd0);

    // add: one-cycle latency from accept
    step(1, 0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, acc);
    in_valid = 1'b0;
    chk("add_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("add_word_direct", out_instr, 32'h0022_1820);
    idle(2);

    // lw then sll with a stray rs on the shift
    step(1, 13, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, acc);
    step(1, 5, 5'd31, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, acc);
    idle(3);
    drain();

    // fill with j while stalled
    rdy_mode = 0;
    idle(1);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 18, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, acc);
      if (acc) n_acc++;
    end
    in_valid = 1'b0;
    chk("full_accepts", 32'(n_acc), 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("held_j_word", out_instr, 32'h0800_0010);
    drain();

    // illegal mnemonic
    step(1, 25, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FFFFFF, acc);
    idle(2);
`ifdef INSTR_ENCODER_CHECK_EN
    chk("illegal_dropped", {31'd0, out_valid}, 32'd0);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_count", {16'd0, count}, 32'(exp_pops));
`else
    chk("illegal_err", {31'd0, err}, 32'd0);
`endif
    drain();

    // randomized traffic with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 500; i++) begin
      int m;
      m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
      step($urandom_range(0, 3) != 0, m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), acc);
    end
    drain();
    chk("random_err", {31'd0, err}, {31'd0, exp_err});

    // reset with three words buffered and a handshake in the reset cycle
    rdy_mode = 0;
    idle(1);
    for (int i = 0; i < 3; i++)
      step(1, 9, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 3), 26'd0, acc);
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    Reset = 1'b1;
    in_valid = 1'b1; mnem = 5'd0;
    exp_q.delete();
    exp_pops = 0;
    exp_err = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    in_valid = 1'b0;
    chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("post_reset_count", {16'd0, count}, 32'd0);
    chk("post_reset_addr", out_addr, BASE);
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset_err", {31'd0, err}, 32'd0);
    @(negedge Clk);
    chk("reset_handshake_ignored", {31'd0, out_valid}, 32'd0);

    rdy_mode = 2;
    step(1, 19, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h123_4567, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
